// File: rtl/clk_div_gen.sv
// Programmable clock divider: bypass or divide-by-R with an H/L duty split.
// Ratio and enable are sampled only in bypass or at a period boundary.
module clk_div_gen #(
  parameter int widthRatio = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic [widthRatio-1:0] div_ratio,
  output logic                  div_clk,
  output logic                  div_tick,
  output logic [widthRatio-1:0] active_ratio
);

  typedef enum logic [1:0] {
    BYPASS,
    HIGH,
    LOW
  } state_t;

  state_t                state_q, state_d;
  logic [widthRatio-1:0] cnt_q, cnt_d;
  logic [widthRatio-1:0] ratio_q, ratio_d;
  logic                  clk_reg_q, clk_reg_d;
  logic                  tick_q, tick_d;
  logic [widthRatio-1:0] hi_len, lo_len;
  logic                  ratio_ok;

  // Any bit above bit 0 set means the ratio is at least 2.
  assign ratio_ok = clk_en && (|div_ratio[widthRatio-1:1]);
  assign lo_len   = ratio_q >> 1;
  assign hi_len   = ratio_q - lo_len;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ratio_d   = ratio_q;
    clk_reg_d = clk_reg_q;
    tick_d    = 1'b0;
    unique case (state_q)
      BYPASS: begin
        cnt_d     = '0;
        ratio_d   = '0;
        clk_reg_d = 1'b0;
        if (ratio_ok) begin
          state_d   = HIGH;
          ratio_d   = div_ratio;
          clk_reg_d = 1'b1;
          cnt_d     = 1;
          tick_d    = 1'b1;
        end
      end
      HIGH: begin
        if (cnt_q == hi_len) begin
          state_d   = LOW;
          clk_reg_d = 1'b0;
          cnt_d     = 1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOW: begin
        if (cnt_q != lo_len) begin
          cnt_d = cnt_q + 1'b1;
        end else if (ratio_ok) begin
          state_d   = HIGH;
          ratio_d   = div_ratio;
          clk_reg_d = 1'b1;
          cnt_d     = 1;
          tick_d    = 1'b1;
        end else begin
          state_d   = BYPASS;
          ratio_d   = '0;
          clk_reg_d = 1'b0;
          cnt_d     = '0;
        end
      end
      default: begin
        state_d   = BYPASS;
        ratio_d   = '0;
        clk_reg_d = 1'b0;
        cnt_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BYPASS;
      cnt_q     <= '0;
      ratio_q   <= '0;
      clk_reg_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ratio_q   <= ratio_d;
      clk_reg_q <= clk_reg_d;
      tick_q    <= tick_d;
    end
  end

  // Reset is included so the output follows clk before the first edge.
  assign div_clk      = (rst || state_q == BYPASS) ? clk : clk_reg_q;
  assign div_tick     = tick_q;
  assign active_ratio = ratio_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen: ratios 4, 5, 8->2, 255,
// enable drop, illegal ratios and mid-period reset.
module tb_clk_div_gen;

  logic       clk;
  logic       rst;
  logic       clk_en;
  logic [7:0] div_ratio;
  logic       div_clk;
  logic       div_tick;
  logic [7:0] active_ratio;

  int n_chk;
  int n_pass;

  clk_div_gen #(.widthRatio(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .clk_en      (clk_en),
    .div_ratio   (div_ratio),
    .div_clk     (div_clk),
    .div_tick    (div_tick),
    .active_ratio(active_ratio)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full divided period; the first step is the sampling edge.
  task automatic run_period(input string tag, input int r,
                            input int chg_at, input int new_ratio,
                            input logic new_en);
    int h;
    h = (r + 1) / 2;
    for (int i = 0; i < r; i++) begin
      step();
      check({tag, "_clk"}, 32'(div_clk), 32'(i < h));
      check({tag, "_tick"}, 32'(div_tick), 32'(i == 0));
      check({tag, "_ratio"}, 32'(active_ratio), 32'(r));
      if (i == chg_at) begin
        div_ratio = 8'(new_ratio);
        clk_en    = new_en;
      end
    end
  endtask

  task automatic check_bypass(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check({tag, "_hi"}, 32'(div_clk), 32'(1));
      check({tag, "_tick"}, 32'(div_tick), 32'(0));
      check({tag, "_ratio"}, 32'(active_ratio), 32'(0));
      @(negedge clk);
      #1;
      check({tag, "_lo"}, 32'(div_clk), 32'(0));
    end
  endtask

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    rst       = 1'b1;
    clk_en    = 1'b1;
    div_ratio = 8'd4;
    check_bypass("rst", 2);

    rst = 1'b0;
    run_period("r4a", 4, -1, 0, 1'b1);
    run_period("r4b", 4, -1, 0, 1'b1);
    run_period("r4c", 4, 3, 5, 1'b1);
    run_period("r5a", 5, -1, 0, 1'b1);
    run_period("r5b", 5, 4, 8, 1'b1);
    run_period("r8", 8, 1, 2, 1'b1);
    run_period("r2a", 2, -1, 0, 1'b1);
    run_period("r2b", 2, 1, 4, 1'b1);
    run_period("r4d", 4, 1, 4, 1'b0);
    check_bypass("en0", 3);

    clk_en    = 1'b1;
    div_ratio = 8'd1;
    check_bypass("div1", 3);
    div_ratio = 8'd0;
    check_bypass("div0", 2);

    div_ratio = 8'd8;
    for (int i = 0; i < 6; i++) step();
    check("mid_low", 32'(div_clk), 32'(0));
    rst = 1'b1;
    check_bypass("rst_mid", 2);
    rst = 1'b0;
    run_period("r8rst", 8, 7, 3, 1'b1);
    run_period("r3", 3, 2, 255, 1'b1);
    run_period("r255", 255, 254, 0, 1'b0);
    check_bypass("end", 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/clk_div_gen.md
CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
REQ-001 Parameter: widthRatio, default 8, width of the divide-ratio input and the active-ratio output.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: clk_en  input  1  divider enable; 0 forces bypass at the next period boundary.
REQ-005 Port: div_ratio  input  widthRatio  requested divide ratio N (1, 2, 4, 8 from the prescale mapper; any value legal).
REQ-006 Port: div_clk  output  1  divided clock; equals clk in bypass, otherwise the registered divided clock.
REQ-007 Port: div_tick  output  1  registered one-cycle pulse marking each div_clk rising edge in divide mode.
REQ-008 Port: active_ratio  output  widthRatio  ratio currently in effect; 0 in bypass.

Function
REQ-009 FSM states SHALL be BYPASS, HIGH and LOW; phase counter cnt SHALL be widthRatio bits.
REQ-010 Latched ratio R: low phase L = R>>1, high phase H = R - L (R=5 -> H=3, L=2; R=4 -> H=2, L=2).
REQ-011 Ratio is "valid" when clk_en=1 and div_ratio>=2; div_ratio of 0 or 1 is never valid.
REQ-012 BYPASS: div_clk = clk (combinational select); div_clk_reg=0; active_ratio=0; div_tick=0.
REQ-013 BYPASS with valid ratio SHALL, on the next edge, latch R=div_ratio, enter HIGH, set div_clk_reg=1, cnt=1, div_tick=1.
REQ-014 HIGH: if cnt==H then enter LOW, div_clk_reg=0, cnt=1; otherwise cnt=cnt+1; div_tick=0.
REQ-015 LOW: if cnt!=L then cnt=cnt+1.
REQ-016 LOW with cnt==L and valid ratio SHALL latch R=div_ratio (new value allowed), enter HIGH, div_clk_reg=1, cnt=1, div_tick=1.
REQ-017 LOW with cnt==L and ratio not valid SHALL enter BYPASS, cnt=0, active_ratio=0.
REQ-018 div_ratio and clk_en SHALL be sampled only in BYPASS and at the LOW->HIGH boundary; changes mid-period SHALL NOT affect the current period.
REQ-019 In divide mode, div_clk period SHALL be exactly R clk cycles, high for H and low for L cycles, with no glitches or runt pulses.
REQ-020 div_tick SHALL be high exactly in the first clk cycle of each HIGH phase; tick spacing = R cycles.
REQ-021 Latency from valid ratio (BYPASS) to first div_clk_reg rise SHALL be 1 cycle.
REQ-022 R=2 SHALL yield H=1, L=1, i.e. div_clk toggles every cycle.
REQ-023 Maximum ratio 2^widthRatio-1 SHALL work without counter overflow (cnt never exceeds H).

Reset
REQ-024 rst=1 at an edge SHALL force state=BYPASS, cnt=0, div_clk_reg=0, div_tick=0, active_ratio=0 regardless of state, including mid-phase.
REQ-025 While rst=1, div_clk SHALL equal clk; first ratio sample SHALL occur at the first edge with rst=0.

Verification
REQ-026 rst released, clk_en=1, div_ratio=4 -> after 1 cycle div_clk_reg high 2 / low 2, div_tick every 4 cycles, active_ratio=4.
REQ-027 div_ratio=5 -> div_clk high 3 cycles, low 2 cycles, period 5, active_ratio=5.
REQ-028 Running at ratio 8, switch div_ratio to 2 during HIGH -> current 8-cycle period completes intact, next period is 2 cycles, active_ratio changes to 2 at that boundary.
REQ-029 Running at ratio 4, drop clk_en to 0 -> current period completes, then BYPASS: div_clk follows clk, active_ratio=0, div_tick stays 0; div_ratio=1 behaves identically.
REQ-030 Assert rst mid-LOW at ratio 8 -> next edge state=BYPASS, outputs at reset values; deassert -> divide restarts with div_tick after 1 cycle.
REQ-031 widthRatio=8, div_ratio=255 -> H=128, L=127, period 255 cycles, no counter wrap.
